// File: rtl/lsu_mem_scheduler.sv
// lsu_mem_scheduler: arbitrates LSQ load misses and store drains onto one outstanding
// memory transaction. Optional performance counters enabled by LSU_SCHED_PERF_EN.
module lsu_mem_scheduler #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned TAG_WIDTH    = 4,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ld_req,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [TAG_WIDTH-1:0]  ld_tag,
  output logic                  ld_gnt,
  output logic                  ld_resp_valid,
  output logic [DATA_WIDTH-1:0] ld_resp_data,
  output logic [TAG_WIDTH-1:0]  ld_resp_tag,
  input  logic                  st_req,
  input  logic [ADDR_WIDTH-1:0] st_addr,
  input  logic [DATA_WIDTH-1:0] st_wdata,
  input  logic                  st_urgent,
  output logic                  st_gnt,
  output logic                  st_done,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  busy
`ifdef LSU_SCHED_PERF_EN
  ,
  output logic [31:0]           perf_ld_grants,
  output logic [31:0]           perf_st_grants,
  output logic [31:0]           perf_starve_overrides,
  output logic [31:0]           perf_wait_cycles
`endif
);

  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [7:0]            starve_cnt_q, starve_cnt_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic                  starved;
  logic                  rule_st;
  logic                  pick_ld;
  logic                  pick_st;

  logic                  ld_gnt_d;
  logic                  ld_resp_valid_d;
  logic [DATA_WIDTH-1:0] ld_resp_data_d;
  logic [TAG_WIDTH-1:0]  ld_resp_tag_d;
  logic                  st_gnt_d;
  logic                  st_done_d;
  logic                  mem_read_d;
  logic                  mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_d;
  logic                  busy_d;

  // Arbitration is only meaningful in IDLE, so a held request cannot be re-granted while busy.
  always_comb begin
    starved = (starve_cnt_q == STARVE_MAX);
    rule_st = 1'b0;
    pick_ld = 1'b0;
    pick_st = 1'b0;
    if (state_q == IDLE) begin
      if (st_req && (st_urgent || starved)) begin
        pick_st = 1'b1;
        rule_st = 1'b1;
      end else if (ld_req) begin
        pick_ld = 1'b1;
      end else if (st_req) begin
        pick_st = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pick_ld) begin
          state_d = RD;
        end else if (pick_st) begin
          state_d = WR;
        end
      end
      RD, WR: begin
        if (mem_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Every output is registered, so this process produces next-cycle output values.
  always_comb begin
    ld_gnt_d        = pick_ld;
    st_gnt_d        = pick_st;
    mem_read_d      = (state_d == RD);
    mem_write_d     = (state_d == WR);
    busy_d          = (state_d != IDLE);
    ld_resp_valid_d = (state_q == RD) && mem_ready;
    st_done_d       = (state_q == WR) && mem_ready;
    ld_resp_data_d  = ld_resp_data;
    ld_resp_tag_d   = ld_resp_tag;
    mem_addr_d      = mem_addr;
    mem_wdata_d     = mem_wdata;
    tag_d           = tag_q;
    starve_cnt_d    = starve_cnt_q;

    if (pick_ld) begin
      mem_addr_d = ld_addr;
      tag_d      = ld_tag;
      if (st_req && (starve_cnt_q < STARVE_MAX)) begin
        starve_cnt_d = starve_cnt_q + 8'd1;
      end
    end

    if (pick_st) begin
      mem_addr_d   = st_addr;
      mem_wdata_d  = st_wdata;
      starve_cnt_d = '0;
    end

    if (ld_resp_valid_d) begin
      ld_resp_data_d = mem_rdata;
      ld_resp_tag_d  = tag_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q  <= '0;
      tag_q         <= '0;
      ld_gnt        <= 1'b0;
      ld_resp_valid <= 1'b0;
      ld_resp_data  <= '0;
      ld_resp_tag   <= '0;
      st_gnt        <= 1'b0;
      st_done       <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      busy          <= 1'b0;
    end else begin
      starve_cnt_q  <= starve_cnt_d;
      tag_q         <= tag_d;
      ld_gnt        <= ld_gnt_d;
      ld_resp_valid <= ld_resp_valid_d;
      ld_resp_data  <= ld_resp_data_d;
      ld_resp_tag   <= ld_resp_tag_d;
      st_gnt        <= st_gnt_d;
      st_done       <= st_done_d;
      mem_read      <= mem_read_d;
      mem_write     <= mem_write_d;
      mem_addr      <= mem_addr_d;
      mem_wdata     <= mem_wdata_d;
      busy          <= busy_d;
    end
  end

`ifdef LSU_SCHED_PERF_EN
  // Overrides count only store wins that actually displaced a pending load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ld_grants        <= '0;
      perf_st_grants        <= '0;
      perf_starve_overrides <= '0;
      perf_wait_cycles      <= '0;
    end else begin
      if (pick_ld) begin
        perf_ld_grants <= perf_ld_grants + 32'd1;
      end
      if (pick_st) begin
        perf_st_grants <= perf_st_grants + 32'd1;
      end
      if (rule_st && ld_req) begin
        perf_starve_overrides <= perf_starve_overrides + 32'd1;
      end
      if ((state_q != IDLE) && !mem_ready) begin
        perf_wait_cycles <= perf_wait_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lsu_mem_scheduler.sv
// Directed testbench for lsu_mem_scheduler with a grant/response/done scoreboard.
module tb_lsu_mem_scheduler;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ld_req;
  logic [AW-1:0] ld_addr;
  logic [TW-1:0] ld_tag;
  logic          ld_gnt;
  logic          ld_resp_valid;
  logic [DW-1:0] ld_resp_data;
  logic [TW-1:0] ld_resp_tag;
  logic          st_req;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_wdata;
  logic          st_urgent;
  logic          st_gnt;
  logic          st_done;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          busy;
`ifdef LSU_SCHED_PERF_EN
  logic [31:0]   perf_ld_grants;
  logic [31:0]   perf_st_grants;
  logic [31:0]   perf_starve_overrides;
  logic [31:0]   perf_wait_cycles;
`endif

  int checks = 0;
  int errors = 0;

  logic             exp_gnt[$];   // 0 = load grant, 1 = store grant
  logic [DW+TW-1:0] exp_resp[$];
  logic             exp_done[$];

  lsu_mem_scheduler #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .TAG_WIDTH   (TW),
    .STARVE_LIMIT(4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ld_req       (ld_req),
    .ld_addr      (ld_addr),
    .ld_tag       (ld_tag),
    .ld_gnt       (ld_gnt),
    .ld_resp_valid(ld_resp_valid),
    .ld_resp_data (ld_resp_data),
    .ld_resp_tag  (ld_resp_tag),
    .st_req       (st_req),
    .st_addr      (st_addr),
    .st_wdata     (st_wdata),
    .st_urgent    (st_urgent),
    .st_gnt       (st_gnt),
    .st_done      (st_done),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .busy         (busy)
`ifdef LSU_SCHED_PERF_EN
    ,
    .perf_ld_grants       (perf_ld_grants),
    .perf_st_grants       (perf_st_grants),
    .perf_starve_overrides(perf_starve_overrides),
    .perf_wait_cycles     (perf_wait_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_gnts(input int n);
    int seen = 0;
    for (int cyc = 0; cyc < 200 && seen < n; cyc++) begin
      @(negedge clk);
      if (ld_gnt || st_gnt) seen++;
    end
    check("gnt_count", 64'(seen), 64'(n));
  endtask

  // Scoreboard: every grant, load response and store completion must match the queues.
  always @(negedge clk) begin
    logic             g;
    logic [DW+TW-1:0] r;
    if (ld_gnt || st_gnt) begin
      if (exp_gnt.size() == 0) begin
        check("unexpected_gnt", 64'({ld_gnt, st_gnt}), 64'd0);
      end else begin
        g = exp_gnt.pop_front();
        check("gnt_kind", 64'({ld_gnt, st_gnt}), g ? 64'd1 : 64'd2);
      end
    end
    if (ld_resp_valid) begin
      if (exp_resp.size() == 0) begin
        check("unexpected_resp", 64'(ld_resp_valid), 64'd0);
      end else begin
        r = exp_resp.pop_front();
        check("resp_data_tag", 64'({ld_resp_data, ld_resp_tag}), 64'(r));
      end
    end
    if (st_done) begin
      if (exp_done.size() == 0) begin
        check("unexpected_done", 64'(st_done), 64'd0);
      end else begin
        g = exp_done.pop_front();
        check("st_done", 64'(st_done), 64'(g));
      end
    end
    check("rd_wr_exclusive", 64'(mem_read & mem_write), 64'd0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ld_req = 1'b0; ld_addr = '0; ld_tag = '0;
    st_req = 1'b0; st_addr = '0; st_wdata = '0; st_urgent = 1'b0;
    mem_rdata = '0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ctrl", 64'({ld_gnt, ld_resp_valid, st_gnt, st_done, mem_read, mem_write, busy}), 64'd0);
    check("reset_data", 64'({ld_resp_data, ld_resp_tag}), 64'd0);
    check("reset_addr", 64'(mem_addr), 64'd0);
    check("reset_wdata", 64'(mem_wdata), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single load, memory answers one cycle after the read command
    ld_req = 1'b1; ld_addr = 32'h100; ld_tag = 4'd3;
    exp_gnt.push_back(1'b0);
    exp_resp.push_back({32'hDEADBEEF, 4'd3});
    @(negedge clk);
    check("s1_ld_gnt", 64'(ld_gnt), 64'd1);
    check("s1_mem_read", 64'({mem_read, mem_write}), 64'd2);
    check("s1_mem_addr", 64'(mem_addr), 64'h100);
    check("s1_busy", 64'(busy), 64'd1);
    ld_req = 1'b0; ld_addr = 32'hFFFF_FFFF;
    @(negedge clk);
    check("s1_hold_read", 64'({ld_gnt, mem_read}), 64'd1);
    check("s1_hold_addr", 64'(mem_addr), 64'h100);
    mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    check("s1_resp_valid", 64'(ld_resp_valid), 64'd1);
    check("s1_resp_data", 64'(ld_resp_data), 64'hDEADBEEF);
    check("s1_resp_tag", 64'(ld_resp_tag), 64'd3);
    check("s1_idle", 64'({busy, mem_read}), 64'd0);
    mem_ready = 1'b0; mem_rdata = '0;
    @(negedge clk);
    check("s1_resp_pulse", 64'(ld_resp_valid), 64'd0);

    // Store with a slow memory: command, address and data held for 5 cycles
    st_req = 1'b1; st_addr = 32'h200; st_wdata = 32'h55;
    exp_gnt.push_back(1'b1);
    exp_done.push_back(1'b1);
    @(negedge clk);
    check("s2_st_gnt", 64'(st_gnt), 64'd1);
    check("s2_mem_write", 64'({mem_read, mem_write}), 64'd1);
    st_req = 1'b0; st_addr = '1; st_wdata = '1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("s2_hold_cmd", 64'({st_gnt, mem_read, mem_write}), 64'd1);
      check("s2_hold_addr", 64'(mem_addr), 64'h200);
      check("s2_hold_wdata", 64'(mem_wdata), 64'h55);
      if (i == 3) mem_ready = 1'b1;
    end
    @(negedge clk);
    check("s2_st_done", 64'(st_done), 64'd1);
    check("s2_idle", 64'({busy, mem_write}), 64'd0);
    check("s2_addr_held", 64'(mem_addr), 64'h200);
    check("s2_wdata_held", 64'(mem_wdata), 64'h55);
    // mem_ready stays high in IDLE and must be ignored
    repeat (3) @(negedge clk);
    check("idle_ready_ignored", 64'({busy, ld_resp_valid, st_done}), 64'd0);
    mem_ready = 1'b0;
`ifdef LSU_SCHED_PERF_EN
    check("perf_wait_cycles", 64'(perf_wait_cycles), 64'd5);
    check("perf_ld_s2", 64'(perf_ld_grants), 64'd1);
    check("perf_st_s2", 64'(perf_st_grants), 64'd1);
`endif
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Both requesters held with a fast memory: L,L,L,L,S repeating
    mem_ready = 1'b1; mem_rdata = 32'hCAFE0000;
    ld_addr = 32'h140; ld_tag = 4'd5; st_addr = 32'h280; st_wdata = 32'h77;
    for (int i = 0; i < 10; i++) begin
      exp_gnt.push_back(i == 4 || i == 9);
      if (i == 4 || i == 9) exp_done.push_back(1'b1);
      else exp_resp.push_back({32'hCAFE0000, 4'd5});
    end
    ld_req = 1'b1; st_req = 1'b1;
    wait_gnts(10);
    ld_req = 1'b0; st_req = 1'b0;
    repeat (3) @(negedge clk);
    check("s3_idle", 64'(busy), 64'd0);
`ifdef LSU_SCHED_PERF_EN
    check("perf_ld_grants", 64'(perf_ld_grants), 64'd8);
    check("perf_st_grants", 64'(perf_st_grants), 64'd2);
    check("perf_starve_overrides", 64'(perf_starve_overrides), 64'd2);
    check("perf_wait_zero", 64'(perf_wait_cycles), 64'd0);
`endif

    // Urgent store jumps ahead and clears the starvation count
    repeat (2) begin
      exp_gnt.push_back(1'b0);
      exp_resp.push_back({32'hCAFE0000, 4'd5});
    end
    ld_req = 1'b1; st_req = 1'b1;
    wait_gnts(2);
    st_urgent = 1'b1;
    exp_gnt.push_back(1'b1);
    exp_done.push_back(1'b1);
    wait_gnts(1);
    st_urgent = 1'b0;
    repeat (4) begin
      exp_gnt.push_back(1'b0);
      exp_resp.push_back({32'hCAFE0000, 4'd5});
    end
    exp_gnt.push_back(1'b1);
    exp_done.push_back(1'b1);
    wait_gnts(5);
    ld_req = 1'b0; st_req = 1'b0;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;

    // Reset while a read is in flight: abandoned without a response
    ld_req = 1'b1; ld_addr = 32'h300; ld_tag = 4'd7;
    exp_gnt.push_back(1'b0);
    @(negedge clk);
    check("s5_ld_gnt", 64'({ld_gnt, mem_read}), 64'd3);
    ld_req = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("s5_async_drop", 64'({mem_read, mem_write, busy, ld_gnt}), 64'd0);
    mem_ready = 1'b1; mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("s5_no_resp", 64'({ld_resp_valid, busy}), 64'd0);

    // Next load after reset, minimum latency
    ld_req = 1'b1; ld_addr = 32'h400; ld_tag = 4'd9;
    mem_ready = 1'b1; mem_rdata = 32'h12345678;
    exp_gnt.push_back(1'b0);
    exp_resp.push_back({32'h12345678, 4'd9});
    @(negedge clk);
    check("s6_ld_gnt", 64'(ld_gnt), 64'd1);
    check("s6_mem_addr", 64'(mem_addr), 64'h400);
    ld_req = 1'b0;
    @(negedge clk);
    check("s6_resp_valid", 64'(ld_resp_valid), 64'd1);
    check("s6_resp_tag", 64'(ld_resp_tag), 64'd9);
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);

    check("gnt_queue_drained", 64'(exp_gnt.size()), 64'd0);
    check("resp_queue_drained", 64'(exp_resp.size()), 64'd0);
    check("done_queue_drained", 64'(exp_done.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_scheduler.md
# lsu_mem_scheduler

Single-port memory scheduler for the load/store unit. It sits between the load-miss path and the store-drain path of the load-store queue and the shared memory interface. It arbitrates the two requesters onto one outstanding memory transaction: loads have priority, and a store starvation counter plus an urgency input bound store latency. It also returns load read data with its tag.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- TAG_WIDTH, 4, load tag width (LSQ index)
- STARVE_LIMIT, 4, consecutive load grants tolerated while a store waits; legal range 1..255

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- ld_req  input  1  load request; held until ld_gnt
- ld_addr  input  ADDR_WIDTH  load address
- ld_tag  input  TAG_WIDTH  load tag, echoed on response
- ld_gnt  output  1  one-cycle pulse: load accepted
- ld_resp_valid  output  1  one-cycle pulse: read data valid
- ld_resp_data  output  DATA_WIDTH  read data
- ld_resp_tag  output  TAG_WIDTH  tag of the returning load
- st_req  input  1  store-drain request; held until st_gnt
- st_addr  input  ADDR_WIDTH  store address
- st_wdata  input  DATA_WIDTH  store data
- st_urgent  input  1  store queue near full; stores win arbitration
- st_gnt  output  1  one-cycle pulse: store accepted
- st_done  output  1  one-cycle pulse: store written
- mem_read, mem_write  output  1 each  memory command, held until mem_ready
- mem_addr  output  ADDR_WIDTH  memory address
- mem_wdata  output  DATA_WIDTH  memory write data
- mem_rdata  input  DATA_WIDTH  memory read data, valid with mem_ready during a read
- mem_ready  input  1  transaction complete
- busy  output  1  state != IDLE

## Operation
- States: IDLE, RD, WR.
- IDLE arbitration, evaluated each cycle in IDLE:
  - Store wins if st_req and (st_urgent or starve_cnt == STARVE_LIMIT).
  - Otherwise load wins if ld_req.
  - Otherwise store wins if st_req.
- Winner effects:
  - Load win: latch addr and tag, go to RD.
  - Store win: latch addr and data, go to WR.
- RD/WR: hold mem_read or mem_write, mem_addr and mem_wdata stable until mem_ready is sampled high, then return to IDLE.
  - On RD completion, register mem_rdata and the latched tag.
- starve_cnt, width 8:
  - Increments, saturating at STARVE_LIMIT, on each load grant made while st_req is high.
  - Clears to 0 on any store grant.
  - Holds otherwise.
- mem_addr and mem_wdata hold their last values in IDLE.
- mem_read and mem_write are never high together.
- mem_ready is ignored in IDLE.
- Reset values: all outputs 0, state IDLE, starve_cnt 0.
- Reset mid-transaction: mem_read and mem_write drop asynchronously. The in-flight transaction is abandoned with no response or done pulse.

## Timing
- All outputs are registered.
- Request sampled in IDLE at cycle N:
  - The grant pulse and mem_read/mem_write are high in cycle N+1.
  - The requester may deassert its request from N+2.
- mem_ready sampled high in cycle M:
  - Read: ld_resp_valid/data/tag, or st_done for a write, pulse in M+1.
  - The state is IDLE in M+1.
- Minimum load latency is request to response = 2 cycles. Peak throughput is one transaction per 2 cycles.
- Simultaneous events:
  - ld_req and st_req in the same IDLE cycle resolve per the priority rules.
  - A request that arrives while busy waits; there is no queueing inside the block.
- Requests are not re-sampled while busy, so a held request cannot be granted twice.

## Configuration
- LSU_SCHED_PERF_EN defined:
  - Adds output perf_ld_grants, 32 bits: increments on each ld_gnt.
  - Adds output perf_st_grants, 32 bits: increments on each st_gnt.
  - Adds output perf_starve_overrides, 32 bits: increments on each store grant won via the starvation or urgent rule while ld_req was also high.
  - Adds output perf_wait_cycles, 32 bits: increments on each cycle in RD/WR with mem_ready low.
  - All counters wrap and reset to 0.
- LSU_SCHED_PERF_EN undefined: these ports and their registers are absent; all other behaviour is identical.

## Test plan
- Single load, addr 0x100, tag 3, mem_ready high 1 cycle after mem_read with rdata 0xDEADBEEF -> ld_gnt at N+1; ld_resp_valid, data 0xDEADBEEF and tag 3 at N+3.
- Store 0x200/0x55, mem_ready delayed 5 cycles -> mem_write, addr and data stable for 5 cycles; st_done one cycle after mem_ready; then busy = 0.
- ld_req and st_req held continuously, STARVE_LIMIT=4, mem_ready always 1 -> grant sequence L,L,L,L,S,L,L,L,L,S…
- st_urgent=1 with both requests pending -> store granted first; starve_cnt cleared.
- rst_n asserted during RD -> mem_read low immediately; no ld_resp_valid after release; next request is serviced normally.
- With LSU_SCHED_PERF_EN, scenario 3 over 10 grants -> perf_ld_grants=8, perf_st_grants=2, perf_starve_overrides=2.
